seq_det_ctrl: RTL

- Controller that sequences a programmable serial pattern detector from a byte stream.
- Accepts bytes on a valid/ready interface and serializes them MSB-first into a pattern matcher, one bit per cycle.
- Counts matches and stops after a programmable target count.
- Used ahead of the team's fixed serial Mealy detectors, making the detection pattern, length and overlap mode run-time configurable.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_matcher.sv | 61 ++++++
 rtl/seq_det_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A pattern length is usable when it is non-zero and fits the history.
  function automatic logic len_legal(input logic [3:0] len, input int max_len);
    return (len != 4'd0) && (32'(len) <= 32'(max_len));
  endfunction

endpackage

// File: rtl/seq_det_matcher.sv
// Bit-serial pattern matcher: shift history, fill count, masked compare.
// The match output is combinational on the bit presented this cycle.
module seq_det_matcher
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid_i,
  input  logic               bit_i,
  input  logic               clear_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [3:0]         len_i,
  input  logic               overlap_i,
  output logic               match_o
);

  localparam int FW = $clog2(MAX_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q;
  logic [FW-1:0]      fill_q;
  logic [MAX_LEN-1:0] hist_next_s;
  logic [FW-1:0]      fill_next_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;

  // Next history/fill and the length-masked comparison against the pattern.
  always_comb begin
    hist_next_s = {hist_q[MAX_LEN-2:0], bit_i};
    if (fill_q == FILL_MAX) begin
      fill_next_s = FILL_MAX;
    end else begin
      fill_next_s = fill_q + {{(FW-1){1'b0}}, 1'b1};
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_i));
    end
    match_s = bit_valid_i && (len_i != 4'd0) &&
              (int'(fill_next_s) >= int'(len_i)) &&
              (((hist_next_s ^ pattern_i) & mask_s) == {MAX_LEN{1'b0}});
  end

  // History and fill update; non-overlap mode discards the matched bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= {MAX_LEN{1'b0}};
      fill_q <= {FW{1'b0}};
    end else if (clear_i) begin
      hist_q <= {MAX_LEN{1'b0}};
      fill_q <= {FW{1'b0}};
    end else if (bit_valid_i) begin
      hist_q <= hist_next_s;
      fill_q <= (match_s && !overlap_i) ? {FW{1'b0}} : fill_next_s;
    end
  end

  assign match_o = match_s;

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencing controller: accepts bytes, serializes them MSB-first into the
// matcher, counts matches and stops once the programmed target is reached.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err_cfg
);

  state_e             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               det_q;
  logic               err_q, err_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;

  logic               bit_valid_s;
  logic               match_s;
  logic               clear_s;
  logic [CNT_W-1:0]   count_inc_s;
  logic [CNT_W-1:0]   count_upd_s;
  logic               target_hit_s;

  seq_det_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk         (clk),
    .rst         (rst),
    .bit_valid_i (bit_valid_s),
    .bit_i       (byte_q[bit_idx_q]),
    .clear_i     (clear_s),
    .pattern_i   (pat_q),
    .len_i       (len_q),
    .overlap_i   (ovl_q),
    .match_o     (match_s)
  );

  // Next-state, serializer, counter and configuration load decisions.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    bit_idx_d = bit_idx_q;
    err_d     = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    tgt_d     = tgt_q;
    clear_s   = 1'b0;

    bit_valid_s = (state_q == SHIFT);
    if (count_q == {CNT_W{1'b1}}) begin
      count_inc_s = count_q;
    end else begin
      count_inc_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    count_upd_s  = match_s ? count_inc_s : count_q;
    count_d      = count_upd_s;
    target_hit_s = match_s && (tgt_q != {CNT_W{1'b0}}) && (count_inc_s == tgt_q);

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ovl_d = cfg_overlap;
          tgt_d = cfg_target;
        end else begin
          pat_d = pat_q;
        end
        if (start) begin
          if (len_legal(len_q, MAX_LEN)) begin
            state_d = WAIT;
            count_d = {CNT_W{1'b0}};
            clear_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (s_valid) begin
          byte_d    = s_data;
          bit_idx_d = 3'd7;
          state_d   = SHIFT;
        end else begin
          state_d = WAIT;
        end
      end
      SHIFT: begin
        if (target_hit_s) begin
          state_d = DONE;
        end else if (bit_idx_q == 3'd0) begin
          state_d = WAIT;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end
      end
      DONE: begin
        if (start) begin
          if (len_legal(len_q, MAX_LEN)) begin
            state_d = WAIT;
            count_d = {CNT_W{1'b0}};
            clear_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides any arm request but keeps a coinciding match count.
    if (abort) begin
      state_d = IDLE;
      clear_s = 1'b1;
      err_d   = 1'b0;
      count_d = count_upd_s;
    end else begin
      clear_s = clear_s;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      byte_q    <= 8'd0;
      bit_idx_q <= 3'd0;
      count_q   <= {CNT_W{1'b0}};
      det_q     <= 1'b0;
      err_q     <= 1'b0;
      pat_q     <= {MAX_LEN{1'b0}};
      len_q     <= 4'd0;
      ovl_q     <= 1'b0;
      tgt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      bit_idx_q <= bit_idx_d;
      count_q   <= count_d;
      det_q     <= match_s;
      err_q     <= err_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
    end
  end

  assign s_ready     = (state_q == WAIT);
  assign busy        = (state_q == WAIT) || (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign det_pulse   = det_q;
  assign match_count = count_q;
  assign err_cfg     = err_q;

endmodule
